neuron_accumulate: RTL and testbench
====================================

# neuron_accumulate

Sequential float_24_8 accumulator that sums a fixed-length stream of weighted terms into one neuron pre-activation value. It feeds the `data_in` port of `sigmoid` directly. A valid/ready handshake on both sides throttles the term stream and holds the finished sum until the downstream stage takes it. One adder is shared across all terms (one term per cycle), so throughput is LENGTH+1 cycles per sum minimum.

## Interface
- `LENGTH`, 16: terms summed per output; legal range 1..65535.
- `CNT_WIDTH`, 16: term counter width; must satisfy 2^CNT_WIDTH > LENGTH.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `data_in` holds a term.
- `in_ready` output 1: block accepts a term this cycle.
- `data_in` input float_24_8: term (sgn, exp[7:0] bias 127, man[22:0]).
- `out_valid` output 1: `data_out` holds a completed sum.
- `out_ready` input 1: downstream takes `data_out`.
- `data_out` output float_24_8: registered sum, connects to `sigmoid.data_in`.
- `bias` input float_24_8: present only with `NEURON_BIAS_EN`.

## Operation
- States are ACCUM and DONE. Reset enters ACCUM with accumulator = +0 and count = 0.
- `in_ready` = (state==ACCUM) & ~`reset`. `out_valid` = (state==DONE).
- A term is accepted when `in_valid` & `in_ready`. On acceptance:
  - acc <= fadd(acc, `data_in`), or fadd(start, `data_in`) when count==0.
  - count increments.
- On the acceptance where count==LENGTH-1:
  - The next state is DONE; count returns to 0.
  - `data_out` loads the final sum on the same edge.
- In DONE:
  - `data_out` is held stable and no terms are accepted.
  - When `out_ready`=1, the next state is ACCUM and acc is cleared to +0.
- fadd rules (single-cycle combinational):
  - An operand with exp==0 is zero, whatever its mantissa.
  - Order operands by magnitude using {exp, man}.
  - Right-shift the smaller hidden-bit mantissa (24 bits) by the exponent difference, truncating the shifted-out bits. A difference ≥ 25 drops the smaller operand.
  - Same signs: add. On carry-out, shift right 1 and exp+1.
  - Differing signs: subtract smaller from larger. The result takes the sign of the larger. Normalize left by leading-zero count, decrementing exp.
  - Overflow (exp ≥ 255) saturates to exp=254, man=all ones, sign kept.
  - Underflow (exp ≤ 0) and exact cancellation both give 32'h00000000.
  - exp==255 inputs are treated as exp=254.
- Reset mid-sum discards partial terms; `data_out` = 0 and `out_valid` = 0 immediately.

## Timing
- Reset values:
  - `in_ready` = 0 while `reset` is high, 1 from the first cycle after release.
  - `out_valid` = 0 and `data_out` = 32'h0.
- Minimum latency is 1 cycle: `out_valid` rises the cycle after the LENGTH-th acceptance.
- A sum completes at best every LENGTH+1 cycles: LENGTH accept cycles plus 1 DONE cycle with `out_ready`=1.
- The first term of the next sum can be accepted the cycle after the DONE handshake.
- `in_valid` low cycles are bubbles; acc and count are unchanged.
- `in_valid`/`data_in` values seen while `in_ready`=0 are ignored.
- With LENGTH=1, every accepted term goes straight to DONE.

## Configuration
- `NEURON_BIAS_EN` defined:
  - The `bias` port exists.
  - start = `bias`, sampled on the same edge that accepts the first term of each sum.
  - The sum is bias + Σ terms.
- Undefined: no `bias` port and start = +0.

## Test plan
- LENGTH=4, terms 3F800000 ×4 with `out_ready`=1 → `data_out`=40800000 (4.0), `out_valid` for 1 cycle, cycle after 4th acceptance.
- LENGTH=2, terms 3FC00000 and BFC00000 → 00000000. Then terms 3F800000 and 30800000 (2^-30) → 3F800000 (operand dropped by alignment).
- LENGTH=2, terms 7F7FFFFF ×2 → 7F7FFFFF (saturation).
- LENGTH=4, `out_ready`=0 for 5 cycles after the sum completes:
  - `data_out` holds stable and `in_ready` stays 0 while `in_valid`=1.
  - After the handshake, the next sum is independent.
- Assert `reset` after 2 of 4 terms, then release and send 4 × 40000000 → 41000000 (8.0); no residue from the earlier terms.
- With `NEURON_BIAS_EN`: `bias`=3F000000 and terms 3F800000 ×4 → 40900000 (4.5).

Source files
------------

// File: rtl/neuron_accumulate.sv
// neuron_accumulate: sums LENGTH float_24_8 terms through one shared adder, one term per cycle.
// Optional feature macro NEURON_BIAS_EN adds a bias port that seeds every sum.
module neuron_accumulate #(
    parameter int LENGTH    = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
`ifdef NEURON_BIAS_EN
    input  logic [31:0] bias,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out
);

    typedef enum logic {ACCUM, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LENGTH - 1);

    state_t               state;
    state_t               next_state;
    logic [31:0]          acc;
    logic [31:0]          start;
    logic [31:0]          add_a;
    logic [31:0]          sum;
    logic [CNT_WIDTH-1:0] count;
    logic                 accept;
    logic                 last_term;

    logic                 sign_a;
    logic                 sign_b;
    logic                 sign_l;
    logic                 a_larger;
    logic                 same_sign;
    logic                 zero_r;
    logic                 ovf_r;
    logic [7:0]           exp_a;
    logic [7:0]           exp_b;
    logic [7:0]           exp_l;
    logic [7:0]           exp_s;
    logic [7:0]           exp_diff;
    logic [23:0]          man_a;
    logic [23:0]          man_b;
    logic [23:0]          man_l;
    logic [23:0]          man_s;
    logic [23:0]          man_al;
    logic [23:0]          man_dif;
    logic [22:0]          man_n;
    logic [24:0]          man_sum;
    logic [4:0]           lz;
    logic [9:0]           exp_r;
    logic [22:0]          frac_r;

`ifdef NEURON_BIAS_EN
    assign start = bias;
`else
    assign start = 32'h0000_0000;
`endif

    // The first term of a sum adds onto the seed instead of whatever acc still holds.
    assign add_a     = (count == '0) ? start : acc;
    assign accept    = in_valid & in_ready;
    assign last_term = (count == LAST);

    function automatic logic [4:0] lead_zeros(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // Single-cycle float add: align by truncating shift, add or subtract, renormalise, clamp.
    always_comb begin
        zero_r = 1'b0;
        exp_r  = 10'h000;
        frac_r = 23'h000000;

        sign_a = add_a[31];
        sign_b = data_in[31];
        exp_a  = (add_a[30:23] == 8'hFF) ? 8'hFE : add_a[30:23];
        exp_b  = (data_in[30:23] == 8'hFF) ? 8'hFE : data_in[30:23];
        man_a  = (add_a[30:23] == 8'h00) ? 24'h000000 : {1'b1, add_a[22:0]};
        man_b  = (data_in[30:23] == 8'h00) ? 24'h000000 : {1'b1, data_in[22:0]};

        a_larger = ({exp_a, man_a} >= {exp_b, man_b});
        sign_l   = a_larger ? sign_a : sign_b;
        exp_l    = a_larger ? exp_a : exp_b;
        exp_s    = a_larger ? exp_b : exp_a;
        man_l    = a_larger ? man_a : man_b;
        man_s    = a_larger ? man_b : man_a;

        exp_diff  = exp_l - exp_s;
        man_al    = (exp_diff >= 8'd25) ? 24'h000000 : (man_s >> exp_diff);
        same_sign = (sign_a == sign_b);

        man_sum = {1'b0, man_l} + {1'b0, man_al};
        man_dif = man_l - man_al;
        lz      = lead_zeros(man_dif);
        man_n   = 23'(man_dif << lz);

        if (same_sign) begin
            zero_r = (man_sum == 25'h0000000);
            exp_r  = {2'b00, exp_l} + {9'h000, man_sum[24]};
            frac_r = man_sum[24] ? man_sum[23:1] : man_sum[22:0];
        end else begin
            exp_r  = {2'b00, exp_l} - {5'b00000, lz};
            zero_r = (man_dif == 24'h000000) | exp_r[9] | (exp_r == 10'h000);
            frac_r = man_n;
        end

        ovf_r = ~exp_r[9] & (exp_r >= 10'd255);

        if (zero_r) begin
            sum = 32'h0000_0000;
        end else if (ovf_r) begin
            sum = {sign_l, 8'hFE, 23'h7FFFFF};
        end else begin
            sum = {sign_l, exp_r[7:0], frac_r};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // in_ready is also gated by reset so nothing looks accepted while reset is held.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = ~reset;
                if (in_valid && !reset && last_term) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            count    <= '0;
            data_out <= '0;
        end else if (accept) begin
            acc <= sum;
            if (last_term) begin
                count    <= '0;
                data_out <= sum;
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
        end else if (state == DONE && out_ready) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_neuron_accumulate.sv
// Scoreboard bench for neuron_accumulate: three instances (LENGTH 4, 2, 1), directed cases then random sums.
// Expected sums come from an integer-arithmetic float model; a monitor pops them when out_valid rises.
module tb_neuron_accumulate;

    typedef struct {
        int          inst;
        logic [31:0] value;
        int          cyc;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  forced_ready;
    logic [2:0]  rnd_ready;
    logic        rand_ready;
    logic [31:0] data_in  [3];
    logic [31:0] data_out [3];
`ifdef NEURON_BIAS_EN
    logic [31:0] bias;
`endif

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    sb_item_t    sb_q [$];
    logic [31:0] stim_q [$];
    logic [31:0] model_acc [3];
    int          model_cnt [3];
    logic [2:0]  prev_valid;
    logic [2:0]  prev_ready;
    logic [31:0] prev_data [3];
    sb_item_t    mon_item;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) rnd_ready <= 3'($urandom_range(0, 7));

    assign out_ready = rand_ready ? rnd_ready : forced_ready;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        neuron_accumulate #(
            .LENGTH   (g == 0 ? 4 : (g == 1 ? 2 : 1)),
            .CNT_WIDTH(16)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .data_in  (data_in[g]),
`ifdef NEURON_BIAS_EN
            .bias     (bias),
`endif
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .data_out (data_out[g])
        );
    end

    function automatic int lenOf(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    endfunction

    function automatic logic [31:0] modelBias();
`ifdef NEURON_BIAS_EN
        return bias;
`else
        return 32'h0000_0000;
`endif
    endfunction

    // Float add done on signed integer significands scaled to the larger exponent.
    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        int     ea;
        int     eb;
        int     e;
        longint ma;
        longint mb;
        longint r;
        longint mag;
        bit     neg;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255) ea = 254;
        if (eb == 255) eb = 254;
        ma = (ea == 0) ? 0 : 8388608 + longint'(a[22:0]);
        mb = (eb == 0) ? 0 : 8388608 + longint'(b[22:0]);
        e  = (ea > eb) ? ea : eb;
        ma = ma >> (e - ea);
        mb = mb >> (e - eb);
        r  = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
        if (r == 0) return 32'h0000_0000;
        neg = (r < 0);
        mag = neg ? -r : r;
        while (mag >= 16777216) begin
            mag = mag >> 1;
            e++;
        end
        while (mag < 8388608) begin
            mag = mag << 1;
            e--;
        end
        if (e >= 255) return {neg, 8'hFE, 23'h7FFFFF};
        if (e <= 0) return 32'h0000_0000;
        return {neg, 8'(e), mag[22:0]};
    endfunction

    function automatic logic [31:0] randFloat();
        logic [7:0] e;
        int         sel;
        sel = int'($urandom_range(0, 19));
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else if (sel == 2) e = 8'(250 + $urandom_range(0, 4));
        else               e = 8'(120 + $urandom_range(0, 15));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, want);
        end
    endtask

    // Presents one term, waits (bounded) for acceptance and advances the model on that edge.
    task automatic sendTerm(input int g, input logic [31:0] v, output bit done,
                            output logic [31:0] res, output int acc_cyc);
        int          waited;
        logic [31:0] seed;
        done    = 1'b0;
        res     = 32'h0;
        acc_cyc = 0;
        waited  = 0;
        @(negedge clk);
        in_valid[g] = 1'b1;
        data_in[g]  = v;
        while (!in_ready[g] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[g]) begin
            checkOutput("in_ready_timeout", 32'(in_ready[g]), 32'd1);
            in_valid[g] = 1'b0;
            return;
        end
        acc_cyc = cyc;
        seed = (model_cnt[g] == 0) ? modelBias() : model_acc[g];
        model_acc[g] = refAdd(seed, v);
        model_cnt[g]++;
        if (model_cnt[g] == lenOf(g)) begin
            model_cnt[g] = 0;
            done = 1'b1;
            res  = model_acc[g];
        end
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic applyStimulus(input int g, input logic [31:0] want, input bit use_const,
                                 input int max_bubble);
        logic [31:0] t;
        logic [31:0] res;
        bit          done;
        int          acc_cyc;
        sb_item_t    item;
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            if (max_bubble > 0) repeat ($urandom_range(0, max_bubble)) @(negedge clk);
            sendTerm(g, t, done, res, acc_cyc);
            if (done) begin
                item.inst  = g;
                item.value = use_const ? want : res;
                item.cyc   = acc_cyc;
                sb_q.push_back(item);
            end
        end
    endtask

    task automatic pushTerms(input logic [31:0] t, input int n);
        for (int k = 0; k < n; k++) stim_q.push_back(t);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: value and latency on each rising out_valid, then hold and stall rules while it stays high.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                prev_valid[i] = 1'b0;
                prev_ready[i] = 1'b0;
                prev_data[i]  = 32'h0;
            end else begin
                if (out_valid[i]) begin
                    checkOutput("in_ready_while_done", 32'(in_ready[i]), 32'd0);
                    if (!prev_valid[i]) begin
                        if (sb_q.size() == 0) begin
                            checkOutput("unexpected_output", 32'(out_valid[i]), 32'd0);
                        end else begin
                            mon_item = sb_q.pop_front();
                            checkOutput("output_instance", 32'(i), 32'(mon_item.inst));
                            checkOutput("sum_value", data_out[i], mon_item.value);
                            checkOutput("output_latency", 32'(cyc), 32'(mon_item.cyc + 1));
                        end
                    end else if (prev_ready[i]) begin
                        checkOutput("valid_after_handshake", 32'(out_valid[i]), 32'd0);
                    end else begin
                        checkOutput("data_out_hold", data_out[i], prev_data[i]);
                    end
                end
                prev_valid[i] = out_valid[i];
                prev_ready[i] = out_ready[i];
                prev_data[i]  = data_out[i];
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rg;
        reset        = 1'b1;
        in_valid     = 3'b000;
        forced_ready = 3'b111;
        rand_ready   = 1'b0;
        prev_valid   = 3'b000;
        prev_ready   = 3'b000;
`ifdef NEURON_BIAS_EN
        bias = 32'h0000_0000;
`endif
        for (int i = 0; i < 3; i++) begin
            data_in[i]   = 32'h0;
            model_acc[i] = 32'h0;
            model_cnt[i] = 0;
            prev_data[i] = 32'h0;
        end

        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_in_ready", 32'(in_ready[i]), 32'd0);
            checkOutput("reset_out_valid", 32'(out_valid[i]), 32'd0);
            checkOutput("reset_data_out", data_out[i], 32'h0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) checkOutput("in_ready_after_reset", 32'(in_ready[i]), 32'd1);

        $display("[TB] directed: 4 x 1.0 on LENGTH=4");
        pushTerms(32'h3F800000, 4);
        applyStimulus(0, 32'h40800000, 1'b1, 0);
        waitDrain();

        $display("[TB] directed: LENGTH=2 cancellation, alignment drop, normalise, saturation");
        stim_q.push_back(32'h3FC00000);
        stim_q.push_back(32'hBFC00000);
        applyStimulus(1, 32'h00000000, 1'b1, 0);
        stim_q.push_back(32'h3F800000);
        stim_q.push_back(32'h30800000);
        applyStimulus(1, 32'h3F800000, 1'b1, 0);
        stim_q.push_back(32'h3F800000);
        stim_q.push_back(32'hBF000000);
        applyStimulus(1, 32'h3F000000, 1'b1, 0);
        pushTerms(32'h7F7FFFFF, 2);
        applyStimulus(1, 32'h7F7FFFFF, 1'b1, 0);
        waitDrain();

        $display("[TB] directed: LENGTH=1 passes each term straight through");
        stim_q.push_back(32'h40400000);
        applyStimulus(2, 32'h40400000, 1'b1, 0);
        stim_q.push_back(32'hC0A00000);
        applyStimulus(2, 32'hC0A00000, 1'b1, 0);
        waitDrain();

        $display("[TB] directed: downstream stall for 5 cycles");
        forced_ready[0] = 1'b0;
        pushTerms(32'h3F800000, 4);
        applyStimulus(0, 32'h40800000, 1'b1, 0);
        repeat (5) begin
            @(negedge clk);
            in_valid[0] = 1'b1;
            data_in[0]  = 32'h4B000000;
            #2;
            checkOutput("stall_out_valid", 32'(out_valid[0]), 32'd1);
            checkOutput("stall_data_out", data_out[0], 32'h40800000);
        end
        @(negedge clk);
        forced_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        pushTerms(32'h40000000, 4);
        applyStimulus(0, 32'h41000000, 1'b1, 0);
        waitDrain();

        $display("[TB] directed: reset in the middle of a sum");
        pushTerms(32'h3F800000, 2);
        applyStimulus(0, 32'h0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_acc[i] = 32'h0;
            model_cnt[i] = 0;
        end
        #1;
        checkOutput("midreset_data_out", data_out[0], 32'h0);
        checkOutput("midreset_out_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_midreset", 32'(in_ready[0]), 32'd1);
        pushTerms(32'h40000000, 4);
        applyStimulus(0, 32'h41000000, 1'b1, 0);
        waitDrain();

`ifdef NEURON_BIAS_EN
        $display("[TB] directed: bias 0.5 plus 4 x 1.0");
        bias = 32'h3F000000;
        pushTerms(32'h3F800000, 4);
        applyStimulus(0, 32'h40900000, 1'b1, 0);
        waitDrain();
        bias = 32'h0000_0000;
`endif

        $display("[TB] random sums with bubbles and random out_ready");
        rand_ready = 1'b1;
        for (int s = 0; s < 40; s++) begin
            rg = int'($urandom_range(0, 2));
`ifdef NEURON_BIAS_EN
            bias = randFloat();
`endif
            for (int k = 0; k < lenOf(rg); k++) stim_q.push_back(randFloat());
            applyStimulus(rg, 32'h0, 1'b0, 2);
        end
        rand_ready   = 1'b0;
        forced_ready = 3'b111;
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
